// File: rtl/hier_leaf_pkg.sv
// hier_leaf_pkg: shared constants, counter-width helper and handshake type for the leaf FIFO
package hier_leaf_pkg;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH = 4;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  typedef struct packed {
    logic valid;
    logic [DEFAULT_DATA_W-1:0] data;
  } hs_t;
endpackage

// File: rtl/hier_leaf_mem.sv
// hier_leaf_mem: DEPTH x DATA_W storage, synchronous write, combinational read
module hier_leaf_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/hier_leaf_fifo.sv
// hier_leaf_fifo: first-word-fall-through FIFO with occupancy, almost-full and sticky peak tracking
module hier_leaf_fifo
  import hier_leaf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AF_LEVEL = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] peak_count
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, r_peak, w_next_count;
  logic w_push, w_pop;
  // in_ready deliberately ignores out_ready: a full FIFO never accepts, even while popping
  assign in_ready = (r_count != FULL) && !rst;
  assign out_valid = r_count != '0;
  assign w_push = in_valid && in_ready;
  assign w_pop = out_valid && out_ready;
  assign count = r_count;
  assign peak_count = r_peak;
  assign almost_full = r_count >= CW'(AF_LEVEL);
  always_comb begin
    w_next_count = (w_push && !w_pop) ? r_count + CW'(1) :
                   (!w_push && w_pop) ? r_count - CW'(1) : r_count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_peak <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_count <= w_next_count;
      if (w_next_count > r_peak) r_peak <= w_next_count;
    end
  end
  hier_leaf_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .i_we(w_push),
    .i_waddr(r_wr_ptr),
    .i_wdata(in_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(out_data)
  );
endmodule

// File: tb/tb_hier_leaf_fifo.sv
// tb_hier_leaf_fifo: directed checks of reset, fill, drain, full-with-pop, wrap and mid-stream reset
module tb_hier_leaf_fifo;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, almost_full;
  logic [7:0] in_data, out_data;
  logic [2:0] count, peak_count;
  int total = 0;
  int bad = 0;
  hier_leaf_fifo #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full), .peak_count(peak_count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    rst = 1; in_valid = 0; out_ready = 0; in_data = 0;
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_peak", peak_count, 0);
    chk("rst_af", almost_full, 0);
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = fill[i];
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i >= 2) ? 1 : 0);
    end
    chk("full_in_ready", in_ready, 0);
    in_data = 8'h55;
    tick();
    chk("full_nopush_count", count, 4);
    chk("full_peak", peak_count, 4);
    chk("full_head", out_data, 8'h11);
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, fill[i]);
      tick();
    end
    chk("drained_valid", out_valid, 0);
    chk("drained_count", count, 0);
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h60 + 8'(i);
      tick();
    end
    chk("refill_count", count, 4);
    in_data = 8'h64;
    out_ready = 1;
    #1;
    chk("fullpop_in_ready", in_ready, 0);
    tick();
    chk("fullpop_count", count, 3);
    chk("fullpop_head", out_data, 8'h61);
    out_ready = 0;
    tick();
    chk("retry_count", count, 4);
    in_valid = 0;
    out_ready = 1;
    for (int i = 1; i < 5; i++) begin
      chk("retry_drain", out_data, 8'h60 + 8'(i));
      tick();
    end
    chk("retry_empty", out_valid, 0);
    out_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i);
      #1;
      chk("wrap_count", count, (i == 0) ? 0 : 1);
      if (i > 0) chk("wrap_data", out_data, i - 1);
      tick();
    end
    in_valid = 0;
    chk("wrap_last", out_data, 8'h09);
    tick();
    chk("wrap_empty", count, 0);
    chk("wrap_peak", peak_count, 1);
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hA0 + 8'(i);
      tick();
    end
    chk("mid_count", count, 3);
    rst = 1;
    in_data = 8'hDD;
    out_ready = 1;
    tick();
    rst = 0;
    in_valid = 0;
    out_ready = 0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_peak", peak_count, 0);
    in_valid = 1;
    in_data = 8'hA5;
    tick();
    in_valid = 0;
    chk("post_valid", out_valid, 1);
    chk("post_data", out_data, 8'hA5);
    chk("post_count", count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hier_leaf_fifo.md
Name: hier_leaf_fifo

Overview:
- Leaf stage of the generated test hierarchy, instantiated beneath the deepest wrapper level.
- Gives the otherwise port-less hierarchy real sequential content: a parameterised first-word-fall-through FIFO with a valid/ready handshake on both sides.
- Includes occupancy, almost-full and peak-occupancy tracking for the elaboration and lint tool flows that exercise the hierarchy.

Parameters:
- DATA_W, 8: payload width in bits; must be 1 or more.
- DEPTH, 4: number of entries; power of two, 2 or more.
- AF_LEVEL, 3: almost_full asserts when count is AF_LEVEL or more; range 1..DEPTH.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has data.
- in_ready  out  1  FIFO can accept data.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry is available.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  DATA_W  head entry payload.
- count  out  $clog2(DEPTH)+1  current occupancy.
- almost_full  out  1  count >= AF_LEVEL.
- peak_count  out  $clog2(DEPTH)+1  highest occupancy since reset (sticky).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the clk rising edge.
- Reset values, registered on the first clk edge with rst=1:
  - wr_ptr=0, rd_ptr=0, count=0, peak_count=0.
  - Outputs after that edge: out_valid=0, almost_full=0, in_ready=1.
  - Storage contents are not reset. out_data is don't-care while out_valid=0.
- in_ready = (count != DEPTH) && !rst. It is a combinational function of registered state and rst only. There is no path from out_ready to in_ready, so while full no push is accepted, even if a pop happens in the same cycle.
- Push on an edge when in_valid && in_ready: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 modulo DEPTH.
- Pop on an edge when out_valid && out_ready: rd_ptr <= rd_ptr+1 modulo DEPTH.
- Handshake: out_valid = (count != 0). out_data = mem[rd_ptr], combinational read.
- Latency: data pushed at edge N is visible on out_data with out_valid=1 in the cycle after edge N. There is no same-cycle bypass, so an empty FIFO never presents in_data directly.
- count update per edge:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
  - count never exceeds DEPTH and never goes below 0.
- Boundary conditions:
  - Full (count=DEPTH) with out_ready=1: pop only, count becomes DEPTH-1.
  - Empty (count=0) with in_valid=1 and out_ready=1: push only, count becomes 1.
  - Pointer wrap: pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer compare.
- almost_full: combinational from count.
- peak_count: updated on an edge when the next count exceeds peak_count, taking that next count. It never decreases except on reset.
- Reset mid-operation: any push or pop in a cycle with rst=1 is discarded. The FIFO is empty on the following cycle.
- Data order is strict FIFO. In-flight data is never dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data holds.

Decomposition:
- Package hier_leaf_pkg:
  - localparam function for counter width (clog2(DEPTH)+1).
  - default constants DEFAULT_DATA_W=8, DEFAULT_DEPTH=4.
  - typedef for the handshake struct {valid, data} used by the benches.
- One sub-module, hier_leaf_mem: DEPTH x DATA_W storage with a synchronous write port and a combinational read port.
- Pointer, count and peak logic stays in hier_leaf_fifo.

Test Plan:
- Reset then idle (rst=1 for 2 cycles, then release) -> count=0, out_valid=0, in_ready=1, peak_count=0, almost_full=0.
- Fill with out_ready=0: push 0x11,0x22,0x33,0x44 on consecutive cycles ->
  - count 1,2,3,4.
  - almost_full rises after the third push.
  - in_ready=0 at count=4; a fifth push of 0x55 is not accepted.
  - peak_count=4.
- Drain with out_ready=1 -> out_data sequence 0x11,0x22,0x33,0x44, then out_valid=0 and count=0; 0x55 never appears.
- Full with in_valid=1 and out_ready=1 for one cycle -> count 4 to 3. The next cycle the push is accepted and count returns to 4.
- Wrap: 10 pushes and 10 pops streaming at count around 1-2 -> output order equals input order 0x00..0x09, pointers wrap twice, peak_count<=2.
- Reset mid-stream at count=3 with simultaneous push and pop -> next cycle count=0, out_valid=0, peak_count=0. A following push of 0xA5 appears as the first output.
